// File: rtl/user_pulse_sched.sv
// Table-driven pulser scheduler: walks the config table and fires the pulser once per
// entry. It waits for DONE under a watchdog, inserts idle gaps and repeats passes.
module user_pulse_sched #(
  parameter int NUM_ENTRIES = 4,
  localparam int IW = $clog2(NUM_ENTRIES)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [87:0]   wr_data_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [IW:0]   num_entries_i,
  input  logic [7:0]    repeat_i,
  input  logic [15:0]   gap_i,
  input  logic [15:0]   timeout_i,
  input  logic [2:0]    pls_state_i,
  output logic          pls_start_o,
  output logic          pls_stop_o,
  output logic [87:0]   pls_cfg_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [IW-1:0] cur_idx_o,
  output logic [7:0]    pass_cnt_o
);

  // state  | meaning
  // IDLE   | waiting for start, table writable
  // LOAD   | latch table[cur_idx] into pls_cfg
  // ISSUE  | one-cycle pulser start strobe
  // WAIT   | waiting for pulser DONE, watchdog running
  // GAP    | idle spacing between bursts
  // FINISH | one-cycle done strobe
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_GAP, S_FINISH
  } state_t;

  localparam logic [IW:0]   NUM_ONE  = 1;
  localparam logic [IW-1:0] IDX_ONE  = 1;
  localparam logic [2:0]    PLS_DONE = 3'd4;

  state_t        state, state_nxt;
  logic [87:0]   tbl [NUM_ENTRIES];
  logic [87:0]   cfg;
  logic [IW-1:0] cur_idx;
  logic [7:0]    pass_cnt;
  logic [7:0]    pass_inc;
  logic [15:0]   wdog_cnt;
  logic [15:0]   gap_cnt;
  logic          err;
  logic          last_entry;
  logic          launch;
  logic          aborting;
  logic          advance;
  logic          wdog_fire;

  assign pass_inc   = pass_cnt + 8'd1;
  assign last_entry = ({1'b0, cur_idx} == (num_entries_i - NUM_ONE));
  assign launch     = (state == S_IDLE) && start_i && (num_entries_i != '0);
  assign aborting   = abort_i && (state != S_IDLE);

  always_comb begin
    state_nxt   = state;
    advance     = 1'b0;
    wdog_fire   = 1'b0;
    pls_start_o = 1'b0;
    pls_stop_o  = 1'b0;
    done_o      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) state_nxt = (num_entries_i != '0) ? S_LOAD : S_FINISH;
      end
      S_LOAD:  state_nxt = S_ISSUE;
      S_ISSUE: begin
        pls_start_o = 1'b1;
        state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        if (pls_state_i == PLS_DONE) begin
          if (gap_i != 16'd0) state_nxt = S_GAP;
          else                advance   = 1'b1;
        end else if ((timeout_i != 16'd0) && (wdog_cnt == timeout_i)) begin
          wdog_fire  = 1'b1;
          pls_stop_o = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt == gap_i - 16'd1) advance = 1'b1;
      end
      S_FINISH: begin
        done_o    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (advance)
      state_nxt = (last_entry && (repeat_i != 8'd0) && (pass_inc == repeat_i)) ? S_FINISH : S_LOAD;

    // Abort overrides everything; start is withheld so the pulser never sees start and stop together.
    if (aborting) begin
      state_nxt   = S_IDLE;
      advance     = 1'b0;
      wdog_fire   = 1'b0;
      pls_start_o = 1'b0;
      done_o      = 1'b0;
      pls_stop_o  = 1'b1;
    end

    if (rst_i) pls_stop_o = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      cfg      <= '0;
      cur_idx  <= '0;
      pass_cnt <= '0;
      err      <= 1'b0;
      wdog_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      state <= state_nxt;

      if (launch) begin
        cur_idx  <= '0;
        pass_cnt <= '0;
        err      <= 1'b0;
      end

      if ((state == S_LOAD) && !abort_i) cfg <= tbl[cur_idx];

      // Both counters restart from zero each time their state is entered.
      if (state == S_WAIT) wdog_cnt <= wdog_cnt + 16'd1;
      else                 wdog_cnt <= '0;
      if (state == S_GAP)  gap_cnt  <= gap_cnt + 16'd1;
      else                 gap_cnt  <= '0;

      if (advance) begin
        if (last_entry) begin
          cur_idx  <= '0;
          pass_cnt <= pass_inc;
        end else begin
          cur_idx <= cur_idx + IDX_ONE;
        end
      end

      if (wdog_fire) err <= 1'b1;
    end
  end

  // The table is deliberately left out of reset so software config survives it.
  always_ff @(posedge clk_i) begin
    if ((state == S_IDLE) && wr_en_i) tbl[wr_idx_i] <= wr_data_i;
  end

  assign pls_cfg_o  = cfg;
  assign busy_o     = (state != S_IDLE);
  assign err_o      = err;
  assign cur_idx_o  = cur_idx;
  assign pass_cnt_o = pass_cnt;

endmodule

// File: tb/tb_user_pulse_sched.sv
// Bench for user_pulse_sched: schedule timeline computed arithmetically per cycle,
// plus hand-computed spot checks for each scenario.
module tb_user_pulse_sched;

  logic        clk_i = 1'b0;
  logic        rst_i, wr_en_i, start_i, abort_i;
  logic [1:0]  wr_idx_i;
  logic [87:0] wr_data_i;
  logic [2:0]  num_entries_i;
  logic [7:0]  repeat_i;
  logic [15:0] gap_i, timeout_i;
  logic [2:0]  pls_state_i;
  logic        pls_start_o, pls_stop_o, busy_o, done_o, err_o;
  logic [87:0] pls_cfg_o;
  logic [1:0]  cur_idx_o;
  logic [7:0]  pass_cnt_o;

  user_pulse_sched #(.NUM_ENTRIES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_idx_i(wr_idx_i),
    .wr_data_i(wr_data_i), .start_i(start_i), .abort_i(abort_i),
    .num_entries_i(num_entries_i), .repeat_i(repeat_i), .gap_i(gap_i),
    .timeout_i(timeout_i), .pls_state_i(pls_state_i), .pls_start_o(pls_start_o),
    .pls_stop_o(pls_stop_o), .pls_cfg_o(pls_cfg_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .cur_idx_o(cur_idx_o), .pass_cnt_o(pass_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = -1;
  always @(posedge clk_i) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Scenario parameters driving the model; cycle numbers are absolute.
  int sc_s, sc_n, sc_r, sc_w, sc_g, sc_t, sc_a, sc_rst, wr_c, resp_d;
  logic [87:0] tb_tbl [4];
  logic [87:0] p_cfg;
  logic [1:0]  p_idx;
  logic [7:0]  p_pass;
  logic        p_err;

  logic        e_busy, e_start, e_stop, e_done, e_err;
  logic [1:0]  e_idx;
  logic [7:0]  e_pass;
  logic [87:0] e_cfg;

  int st_q[$], dn_q[$], done_q[$], stop_q[$];
  logic [87:0] stcfg_q[$];
  int b_st, b_dn, b_done, b_stop;

  // Slot k of a schedule starting at s occupies cycles s+1+k*P .. s+k*P+P, P = W+gap+2:
  // LOAD, ISSUE, W wait cycles, gap cycles. FINISH sits at slot index N*R.
  task automatic model_eval(input int c);
    int per, kmax, fin, term, ki, m, k;
    logic tmo;
    e_busy = 0; e_start = 0; e_stop = 0; e_done = 0;
    e_idx = p_idx; e_pass = p_pass; e_cfg = p_cfg; e_err = p_err;
    if (sc_rst >= 0 && c > sc_rst) begin
      e_idx = 0; e_pass = 0; e_cfg = '0; e_err = 0;
      return;
    end
    if (c <= sc_s) return;
    if (sc_n == 0) begin
      if (c == sc_s + 1) begin e_busy = 1; e_done = 1; end
      return;
    end
    per  = sc_w + sc_g + 2;
    kmax = (sc_r == 0) ? 32'h7fffffff : sc_n * sc_r;
    fin  = (sc_r == 0) ? 32'h7fffffff : sc_s + 1 + kmax * per;
    term = 32'h7fffffff;
    tmo  = 0;
    if (sc_a >= 0) term = sc_a;
    if (sc_t > 0 && sc_s + 3 + sc_t < term) begin term = sc_s + 3 + sc_t; tmo = 1; end
    ki = (c > term) ? term : c;
    if (ki > fin) ki = fin;
    m = ki - (sc_s + 1);
    k = m / per;
    e_idx  = 2'(k % sc_n);
    e_pass = 8'((k / sc_n) % 256);
    e_err  = 0;
    if (ki >= sc_s + 2) e_cfg = tb_tbl[((ki - sc_s - 2) / per) % sc_n];
    if (c > term) begin e_err = tmo; return; end
    if (c > fin) return;
    e_busy = 1;
    if (c == term) begin e_stop = 1; return; end
    if (c == fin) e_done = 1;
    else if (m % per == 1) e_start = 1;
  endtask

  // Per-cycle compare against the model, plus event logging for spot checks.
  initial forever begin
    @(negedge clk_i);
    if (pls_start_o) begin st_q.push_back(cyc); stcfg_q.push_back(pls_cfg_o); end
    if (pls_state_i == 3'd4) dn_q.push_back(cyc);
    if (done_o) done_q.push_back(cyc);
    if (pls_stop_o) stop_q.push_back(cyc);
    if (cyc >= 1) begin
      model_eval(cyc);
      tests++;
      if (busy_o !== e_busy || pls_start_o !== e_start || pls_stop_o !== e_stop ||
          done_o !== e_done || err_o !== e_err || cur_idx_o !== e_idx ||
          pass_cnt_o !== e_pass || pls_cfg_o !== e_cfg) begin
        fails++;
        $display("FAIL cycle %0d outputs: got busy=%b start=%b stop=%b done=%b err=%b idx=%0d pass=%0d cfg=%h, expected busy=%b start=%b stop=%b done=%b err=%b idx=%0d pass=%0d cfg=%h",
                 cyc, busy_o, pls_start_o, pls_stop_o, done_o, err_o, cur_idx_o, pass_cnt_o, pls_cfg_o,
                 e_busy, e_start, e_stop, e_done, e_err, e_idx, e_pass, e_cfg);
      end
    end
  end

  // Pulser stand-in: reports DONE for one cycle resp_d cycles after each start (0 = never).
  int cd = 0;
  initial begin
    pls_state_i = 3'd0;
    forever begin
      @(negedge clk_i);
      if (pls_start_o && resp_d > 0) cd = resp_d;
      @(posedge clk_i);
      #1;
      if (cd > 0) begin
        cd--;
        pls_state_i = (cd == 0) ? 3'd4 : 3'd0;
      end else begin
        pls_state_i = 3'd0;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic lit(input string name, input logic [87:0] got, input logic [87:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic launch(input int n, input int r, input int g, input int w, input int d,
                        input int t, input int a_off, input int r_off, input int w_off,
                        input int len);
    step();
    model_eval(cyc);
    p_idx = e_idx; p_pass = e_pass; p_cfg = e_cfg; p_err = e_err;
    sc_s = cyc; sc_n = n; sc_r = r; sc_g = g; sc_w = w; sc_t = t;
    sc_a   = (a_off < 0) ? -1 : cyc + a_off;
    sc_rst = (r_off < 0) ? -1 : cyc + r_off;
    wr_c   = (w_off < 0) ? -1 : cyc + w_off;
    resp_d = d;
    b_st = st_q.size(); b_dn = dn_q.size(); b_done = done_q.size(); b_stop = stop_q.size();
    num_entries_i = 3'(n); repeat_i = 8'(r); gap_i = 16'(g); timeout_i = 16'(t);
    start_i = 1;
    repeat (len) begin
      step();
      start_i = 0;
      abort_i = (cyc == sc_a);
      rst_i   = (cyc == sc_rst);
      wr_en_i = (cyc == wr_c);
    end
    step();
    abort_i = 0; rst_i = 0; wr_en_i = 0;
  endtask

  initial begin
    logic [87:0] ent [4];
    ent[0] = 88'h11_22_33_0100_0080_0200_0180;
    ent[1] = 88'h44_55_66_0300_0280_0400_0380;
    ent[2] = 88'h77_88_99_0500_0480_0600_0580;
    ent[3] = 88'hAA_BB_CC_0700_0680_0800_0780;
    rst_i = 1; wr_en_i = 0; wr_idx_i = 0; wr_data_i = '0; start_i = 0; abort_i = 0;
    num_entries_i = 0; repeat_i = 0; gap_i = 0; timeout_i = 0;
    sc_s = 32'h7fffffff; sc_n = 0; sc_r = 0; sc_w = 0; sc_g = 0; sc_t = 0;
    sc_a = -1; sc_rst = 0; wr_c = -1; resp_d = 0;
    p_cfg = '0; p_idx = 0; p_pass = 0; p_err = 0;
    for (int i = 0; i < 4; i++) tb_tbl[i] = '0;

    step();
    rst_i = 0;
    lit("reset busy", 88'(busy_o), 88'd0);
    lit("reset cfg", pls_cfg_o, 88'd0);
    for (int i = 0; i < 4; i++) begin
      wr_en_i = 1; wr_idx_i = 2'(i); wr_data_i = ent[i]; tb_tbl[i] = ent[i];
      step();
    end
    wr_en_i = 0;

    // Two entries, one pass, DONE 10 cycles after each start.
    launch(2, 1, 0, 10, 10, 0, -1, -1, -1, 30);
    lit("s1 start count", 88'(st_q.size() - b_st), 88'd2);
    lit("s1 cfg first", stcfg_q[b_st], 88'h11_22_33_0100_0080_0200_0180);
    lit("s1 cfg second", stcfg_q[b_st + 1], 88'h44_55_66_0300_0280_0400_0380);
    lit("s1 start spacing", 88'(st_q[b_st + 1] - st_q[b_st]), 88'd12);
    lit("s1 done count", 88'(done_q.size() - b_done), 88'd1);
    lit("s1 pass count", 88'(pass_cnt_o), 88'd1);

    // gap 5: DONE to next start is 7 cycles.
    launch(2, 1, 5, 4, 4, 0, -1, -1, -1, 28);
    lit("s2 done to next start", 88'(st_q[b_st + 1] - dn_q[b_dn]), 88'd7);

    // Infinite repeat over 3 entries, aborted in the GAP of the eighth burst.
    launch(3, 0, 2, 3, 3, 0, 55, -1, -1, 60);
    lit("s3 start count", 88'(st_q.size() - b_st), 88'd8);
    lit("s3 stop count", 88'(stop_q.size() - b_stop), 88'd1);
    lit("s3 done count", 88'(done_q.size() - b_done), 88'd0);
    lit("s3 cur idx", 88'(cur_idx_o), 88'd1);
    lit("s3 pass count", 88'(pass_cnt_o), 88'd2);

    // Watchdog: pulser never finishes.
    launch(1, 1, 0, 1000, 0, 20, -1, -1, -1, 30);
    lit("s4 stop after wait entry", 88'(stop_q[b_stop] - (sc_s + 3)), 88'd20);
    lit("s4 err", 88'(err_o), 88'd1);
    lit("s4 busy", 88'(busy_o), 88'd0);

    // Next start clears err; a write while busy must not reach the table.
    wr_idx_i = 2'd1; wr_data_i = 88'hDE_AD_BE_EF00_0000_0000_0000;
    launch(2, 1, 0, 2, 2, 0, -1, -1, 3, 14);
    lit("s5 err cleared", 88'(err_o), 88'd0);
    lit("s5 cfg second", stcfg_q[b_st + 1], 88'h44_55_66_0300_0280_0400_0380);

    // Zero entries: done on the next cycle, no pulser start.
    launch(0, 1, 0, 1, 1, 0, -1, -1, -1, 4);
    lit("s6 done count", 88'(done_q.size() - b_done), 88'd1);
    lit("s6 done latency", 88'(done_q[b_done] - sc_s), 88'd1);
    lit("s6 start count", 88'(st_q.size() - b_st), 88'd0);

    // Reset while waiting on the pulser.
    launch(2, 1, 0, 10, 10, 0, -1, 5, -1, 12);
    lit("s7 busy", 88'(busy_o), 88'd0);
    lit("s7 cfg", pls_cfg_o, 88'd0);

    // Table content survives reset.
    launch(1, 2, 0, 1, 1, 0, -1, -1, -1, 10);
    lit("s8 pass count", 88'(pass_cnt_o), 88'd2);
    lit("s8 cfg", pls_cfg_o, 88'h11_22_33_0100_0080_0200_0180);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/user_pulse_sched.md
USER_PULSE_SCHED -- requirements
Module: user_pulse_sched

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 4, meaning config-table depth (power of 2, 2..16); IW = $clog2(NUM_ENTRIES).
REQ-002 SHALL have port clk_i  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port wr_en_i  in  1  table write strobe.
REQ-005 SHALL have port wr_idx_i  in  IW  table write index.
REQ-006 SHALL have port wr_data_i  in  88  entry {f1_cnt[87:80], f2_cnt[79:72], stop_cnt[71:64], f1_end[63:48], f1_switch[47:32], f2_end[31:16], f2_switch[15:0]}.
REQ-007 SHALL have port start_i  in  1  begin schedule.
REQ-008 SHALL have port abort_i  in  1  terminate schedule.
REQ-009 SHALL have port num_entries_i  in  IW+1  entries per pass, 0..NUM_ENTRIES.
REQ-010 SHALL have port repeat_i  in  8  passes; 0 = infinite.
REQ-011 SHALL have port gap_i  in  16  idle cycles between bursts.
REQ-012 SHALL have port timeout_i  in  16  watchdog limit in WAIT; 0 = disabled.
REQ-013 SHALL have port pls_state_i  in  3  pulser state; 3'd0 IDLE, 3'd4 DONE.
REQ-014 SHALL have port pls_start_o / pls_stop_o  out  1 each  pulser start/stop strobes.
REQ-015 SHALL have port pls_cfg_o  out  88  current entry, same packing as wr_data_i.
REQ-016 SHALL have port busy_o, done_o, err_o  out  1 each; cur_idx_o  out  IW; pass_cnt_o  out  8.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, ISSUE, WAIT, GAP, FINISH.
REQ-018 SHALL write wr_data_i to entry wr_idx_i on wr_en_i only when state==IDLE; writes in other states ignored; table not reset.
REQ-019 IDLE: start_i with num_entries_i>0 SHALL go to LOAD, clear cur_idx_o, pass_cnt_o, err_o; with num_entries_i==0 SHALL go to FINISH.
REQ-020 LOAD (1 cycle): SHALL register table[cur_idx] into pls_cfg_o, then ISSUE.
REQ-021 ISSUE (1 cycle): pls_start_o SHALL be 1, then WAIT; pls_start_o 0 in all other states.
REQ-022 WAIT: on pls_state_i==3'd4 SHALL go to GAP if gap_i>0, else advance (REQ-024) directly.
REQ-023 WAIT watchdog: 16-bit counter cleared on WAIT entry, incremented each WAIT cycle; when timeout_i>0 and count==timeout_i, SHALL assert pls_stop_o one cycle, set err_o, go IDLE without done_o.
REQ-024 GAP: SHALL hold gap_i cycles exactly, then advance: cur_idx+1; if cur_idx==num_entries_i-1, cur_idx wraps to 0 and pass_cnt increments (8-bit, wraps 255->0); if repeat_i!=0 and incremented pass_cnt==repeat_i go FINISH, else LOAD.
REQ-025 Issue-to-issue spacing SHALL be (WAIT cycles)+gap_i+2.
REQ-026 FINISH (1 cycle): done_o SHALL be 1, then IDLE; done_o 0 elsewhere.
REQ-027 busy_o SHALL be 1 in every state except IDLE.
REQ-028 pls_cfg_o SHALL change only in LOAD, stable through ISSUE/WAIT/GAP.
REQ-029 abort_i in any non-IDLE state SHALL have priority over all transitions: pls_stop_o=1 that cycle (combinational), next state IDLE, no done_o, err_o unchanged; abort_i in IDLE ignored.
REQ-030 start_i while busy_o SHALL be ignored.
REQ-031 num_entries_i, repeat_i, gap_i, timeout_i SHALL be sampled live; changes mid-schedule are software error, no recovery required beyond REQ-029.

Reset
REQ-032 rst_i SHALL force IDLE, pls_cfg_o=0, cur_idx_o=0, pass_cnt_o=0, err_o=0, all strobes 0, counters 0, on the next edge, including mid-schedule; pls_stop_o NOT asserted by reset.

Verification
REQ-033 2 entries, repeat_i=1, gap_i=0, DONE 10 cycles after each start -> two pls_start_o pulses, cfg entry0 then entry1, one done_o, pass_cnt_o=1.
REQ-034 gap_i=5 -> DONE seen in cycle t gives next pls_start_o at t+7.
REQ-035 repeat_i=0, 3 entries -> cur_idx_o 0,1,2,0..., pass_cnt_o increments; abort_i in GAP -> pls_stop_o pulse, IDLE, no done_o.
REQ-036 timeout_i=20, pls_state_i never 4 -> pls_stop_o and err_o 20 cycles after WAIT entry; next start_i clears err_o.
REQ-037 wr_en_i while busy -> table unchanged; start_i with num_entries_i=0 -> done_o next cycle, no pls_start_o.
REQ-038 rst_i asserted in WAIT -> next cycle IDLE, all outputs reset values.
